hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline stall unit. Replaces the fixed E/M-stage Tuse/Tnew comparison with a per-register scoreboard of remaining Tnew countdowns, so pipelines of any depth and latency mix are covered without per-stage decode.
- Also owns the multi-cycle mult/div busy timer, so HI/LO interlock is generated internally.
- Sits beside the D stage. Consumes D-stage decode fields and drives the single stall (freeze F/D, bubble into E).

Parameters:
- NREG, 32: architectural register count; register 0 is hard-wired zero.
- AW, 5: register address width, equal to clog2(NREG).
- TW, 3: Tnew/Tuse field width; maximum representable latency is 2^TW-1.
- MULT_LAT, 5: busy cycles for mult/multu.
- DIV_LAT, 10: busy cycles for div/divu.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- flush, input, 1: kill all in-flight writers (exception/eret); synchronous.
- d_valid, input, 1: D holds a real instruction, not a bubble.
- d_rs_addr, input, AW: D source rs.
- d_rt_addr, input, AW: D source rt.
- d_tuse_rs, input, TW: Tuse for rs; all-ones means rs is not used.
- d_tuse_rt, input, TW: Tuse for rt; all-ones means rt is not used.
- d_wr_en, input, 1: the D instruction writes the GPR file.
- d_wr_addr, input, AW: GPR destination.
- d_tnew, input, TW: Tnew the instruction will have on entering E (load=2, ALU/lui/shift/mf=1, link=0).
- d_hilo_use, input, 1: D instruction is md, mf or mt.
- d_md_start, input, 1: D instruction is a mult/div.
- d_md_is_div, input, 1: selects DIV_LAT instead of MULT_LAT.
- stall, output, 1: hold F/D and insert a bubble into E.
- issue, output, 1: d_valid & ~stall, i.e. the D instruction advances this cycle.
- md_busy, output, 1: mult/div timer non-zero.
- stall_raw, output, 1: GPR component of stall.
- stall_md, output, 1: HI/LO component of stall.

Behaviour:
- State:
  - cnt[1..NREG-1], TW bits each, holding the remaining Tnew of the youngest in-flight writer; cnt[0] is constant 0.
  - md_cnt, width clog2(max(MULT_LAT,DIV_LAT)+1).
- Reset: all cnt, md_cnt and stats cleared. Outputs stall=0, issue=d_valid, md_busy=0.
- Hazard (combinational on current state):
  - stall_rs = d_valid & (d_tuse_rs != all-ones) & (cnt[d_rs_addr] > d_tuse_rs).
  - stall_rt is the same with rt.
  - stall_raw = stall_rs | stall_rt.
  - stall_md = d_valid & d_hilo_use & md_busy.
  - stall = stall_raw | stall_md.
- Scoreboard update, every cycle:
  - Each non-zero cnt decrements by 1 and saturates at 0.
  - If issue & d_wr_en & (d_wr_addr != 0), then cnt[d_wr_addr] <= d_tnew. This load overrides the decrement on the same entry, so the youngest writer wins even if an older one is still counting.
  - A writer with d_tnew=0 loads 0, so it never stalls anyone.
- Timing: the consumer one slot behind sees cnt = d_tnew on the next cycle. This matches the E-stage rule Tuse < Tnew → stall. Examples:
  - lw followed by addu: 1 stall cycle.
  - lw followed by beq: 2 stall cycles.
  - ALU result followed by beq: 1 stall cycle.
- MD timer:
  - If issue & d_md_start, md_cnt <= d_md_is_div ? DIV_LAT : MULT_LAT.
  - Otherwise md_cnt decrements while non-zero.
  - md_busy = (md_cnt != 0).
  - A new mult/div issued while md_busy is impossible, because d_hilo_use covers it and it stalls.
- Flush: all cnt and md_cnt cleared next cycle, and issue is suppressed that cycle. Flush has priority over issue loads. reset has priority over flush.
- Saturation: d_tnew > 2^TW-2 is illegal; the result is undefined and checked by assertion.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Three 32-bit saturating counters: raw_stall_cycles, md_stall_cycles, issued_instrs. Each increments on stall_raw, stall_md and issue respectively; a cycle with both stall components counts in both.
  - Exposed as output ports stat_raw, stat_md, stat_issue.
  - Cleared on reset only, not on flush.
- When undefined: the ports and counters are absent and timing is unaffected.

Decomposition:
- Shared package cpu_pkg holds:
  - TUSE_NONE (all-ones);
  - TNEW_LOAD=2, TNEW_ALU=1, TNEW_LINK=0;
  - MULT_LAT and DIV_LAT defaults.
- One natural sub-module, md_busy_timer: a load/decrement counter that produces md_busy, instantiated once.
- The scoreboard array stays inline.

Test Plan:
- lw $1 (tnew 2) issues; next cycle D=addu $2,$1,$3 (tuse_rs 1) → stall=1 for 1 cycle, then issue=1.
- lw $1 then D=beq $1,$0 (tuse 0) → stall for 2 cycles; addu $1 then beq $1 → stall for 1 cycle.
- addu $0,... (tnew 1) then beq $0 → stall never asserted; cnt[0] stays 0.
- mult issues (MULT_LAT 5); next D=mfhi → stall_md=1 for 5 cycles, issue on the 6th; with div the stall lasts 10 cycles.
- lw $4 issues, then flush next cycle → all cnt=0; D=addu using $4 → no stall. reset mid-mult → md_busy=0 the next cycle.
- HAZARD_STATS_EN: lw→addu→mult→mflo sequence → stat_raw=1, stat_md=5, stat_issue=4.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline timing constants for the hazard scoreboard
package cpu_pkg;

  // Default Tnew/Tuse field width; all-ones in a Tuse field means "operand unused".
  localparam int TW_DEFAULT = 3;
  localparam logic [TW_DEFAULT-1:0] TUSE_NONE = '1;

  // Tnew an instruction carries when it enters E.
  localparam logic [TW_DEFAULT-1:0] TNEW_LOAD = 3'd2;
  localparam logic [TW_DEFAULT-1:0] TNEW_ALU  = 3'd1;
  localparam logic [TW_DEFAULT-1:0] TNEW_LINK = 3'd0;

  // Mult/div unit busy cycles.
  localparam int MULT_LAT_DEFAULT = 5;
  localparam int DIV_LAT_DEFAULT  = 10;

  // Larger of two integers, used to size the busy timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// rtl/md_busy_timer.sv - load/decrement busy timer for the mult/div unit
module md_busy_timer
  import cpu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_flush,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);

  localparam int CW = $clog2(max_int(MULT_LAT, DIV_LAT) + 1);

  logic [CW-1:0] r_cnt;

  // Load the latency of the issuing op, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register Tnew scoreboard and D-stage stall unit (optional HAZARD_STATS_EN counters)
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int TW       = TW_DEFAULT,
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs_addr,
  input  logic [AW-1:0] d_rt_addr,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_wr_en,
  input  logic [AW-1:0] d_wr_addr,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_hilo_use,
  input  logic          d_md_start,
  input  logic          d_md_is_div,
  output logic          stall,
  output logic          issue,
  output logic          md_busy,
  output logic          stall_raw,
  output logic          stall_md
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]   stat_raw,
  output logic [31:0]   stat_md,
  output logic [31:0]   stat_issue
`endif
);

  // Remaining Tnew of the youngest in-flight writer of each register.
  logic [TW-1:0] r_cnt [NREG];

  logic [TW-1:0] w_cnt_rs;
  logic [TW-1:0] w_cnt_rt;
  logic          w_stall_rs;
  logic          w_stall_rt;
  logic          w_load;
  logic          w_md_start;

  assign w_cnt_rs   = r_cnt[d_rs_addr];
  assign w_cnt_rt   = r_cnt[d_rt_addr];

  // An operand stalls when its producer still needs more cycles than the consumer can wait.
  assign w_stall_rs = d_valid & (d_tuse_rs != '1) & (w_cnt_rs > d_tuse_rs);
  assign w_stall_rt = d_valid & (d_tuse_rt != '1) & (w_cnt_rt > d_tuse_rt);

  assign stall_raw  = w_stall_rs | w_stall_rt;
  assign stall_md   = d_valid & d_hilo_use & md_busy;
  assign stall      = stall_raw | stall_md;
  assign issue      = d_valid & ~stall & ~flush;

  assign w_load     = issue & d_wr_en & (d_wr_addr != '0);
  assign w_md_start = issue & d_md_start;

  // Countdown per register; a new writer's load replaces any older countdown on that entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reset || flush || (i == 0)) begin
        r_cnt[i] <= '0;
      end else if (w_load && (d_wr_addr == AW'(i))) begin
        r_cnt[i] <= d_tnew;
      end else if (r_cnt[i] != '0) begin
        r_cnt[i] <= r_cnt[i] - TW'(1);
      end
    end
  end

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_timer (
    .clk      (clk),
    .reset    (reset),
    .i_flush  (flush),
    .i_start  (w_md_start),
    .i_is_div (d_md_is_div),
    .o_busy   (md_busy)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stat_raw;
  logic [31:0] r_stat_md;
  logic [31:0] r_stat_issue;

  // Saturating event counters; only reset clears them so they survive exceptions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_raw   <= '0;
      r_stat_md    <= '0;
      r_stat_issue <= '0;
    end else begin
      if (stall_raw && (r_stat_raw != '1)) begin
        r_stat_raw <= r_stat_raw + 32'd1;
      end
      if (stall_md && (r_stat_md != '1)) begin
        r_stat_md <= r_stat_md + 32'd1;
      end
      if (issue && (r_stat_issue != '1)) begin
        r_stat_issue <= r_stat_issue + 32'd1;
      end
    end
  end

  assign stat_raw   = r_stat_raw;
  assign stat_md    = r_stat_md;
  assign stat_issue = r_stat_issue;
`endif

  // An all-ones Tnew cannot be counted down reliably, so it must never be loaded.
  a_tnew_legal: assert property (@(posedge clk) disable iff (reset)
    w_load |-> (d_tnew != '1));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench with an absolute-time reference model
module tb_hazard_scoreboard;
  import cpu_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       d_valid = 1'b0;
  logic [4:0] d_rs_addr = '0;
  logic [4:0] d_rt_addr = '0;
  logic [2:0] d_tuse_rs = '0;
  logic [2:0] d_tuse_rt = '0;
  logic       d_wr_en = 1'b0;
  logic [4:0] d_wr_addr = '0;
  logic [2:0] d_tnew = '0;
  logic       d_hilo_use = 1'b0;
  logic       d_md_start = 1'b0;
  logic       d_md_is_div = 1'b0;
  logic       stall, issue, md_busy, stall_raw, stall_md;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_raw, stat_md, stat_issue;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREG(32), .AW(5), .TW(3), .MULT_LAT(ML), .DIV_LAT(DL)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
    .d_hilo_use(d_hilo_use), .d_md_start(d_md_start), .d_md_is_div(d_md_is_div),
    .stall(stall), .issue(issue), .md_busy(md_busy),
    .stall_raw(stall_raw), .stall_md(stall_md)
`ifdef HAZARD_STATS_EN
    , .stat_raw(stat_raw), .stat_md(stat_md), .stat_issue(stat_issue)
`endif
  );

  typedef struct {
    bit       v;
    bit [4:0] rs;
    bit [2:0] trs;
    bit [4:0] rt;
    bit [2:0] trt;
    bit       wr;
    bit [4:0] wa;
    bit [2:0] tn;
    bit       hl;
    bit       md;
    bit       dv;
  } ins_t;

  typedef struct {
    longint      cyc;
    bit          stall, issue, busy, raw, mdst;
    int unsigned s_raw, s_md, s_iss;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  longint      cyc = 0;
  // Model: absolute cycle at which each register's value becomes available, and when mult/div frees.
  longint      avail[32];
  longint      md_free = 0;
  int unsigned m_raw = 0, m_md = 0, m_iss = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  function automatic ins_t mk(input bit [4:0] rs, input bit [2:0] trs, input bit [4:0] rt,
                              input bit [2:0] trt, input bit wr, input bit [4:0] wa,
                              input bit [2:0] tn, input bit hl, input bit md, input bit dv);
    ins_t i;
    i.v = 1'b1; i.rs = rs; i.trs = trs; i.rt = rt; i.trt = trt;
    i.wr = wr; i.wa = wa; i.tn = tn; i.hl = hl; i.md = md; i.dv = dv;
    return i;
  endfunction

  function automatic ins_t bubble();
    ins_t i;
    i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    i.v = 1'b0;
    return i;
  endfunction

  function automatic longint remaining(input bit [4:0] r, input longint c);
    if (r == 0) return 0;
    return (avail[r] > c) ? avail[r] - c : 0;
  endfunction

  // One clock: drive D, predict outputs from the model, queue them, advance the model.
  task automatic step(input ins_t i, input bit fl, input bit rst,
                      output bit m_issued, output bit d_stalled);
    bit   e_rs, e_rt, e_raw, e_md, e_busy, e_stall, e_iss;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst; flush = fl; d_valid = i.v;
    d_rs_addr = i.rs; d_rt_addr = i.rt; d_tuse_rs = i.trs; d_tuse_rt = i.trt;
    d_wr_en = i.wr; d_wr_addr = i.wa; d_tnew = i.tn;
    d_hilo_use = i.hl; d_md_start = i.md; d_md_is_div = i.dv;
    e_rs    = i.v && (i.trs != TUSE_NONE) && (remaining(i.rs, cyc) > longint'(i.trs));
    e_rt    = i.v && (i.trt != TUSE_NONE) && (remaining(i.rt, cyc) > longint'(i.trt));
    e_raw   = e_rs || e_rt;
    e_busy  = cyc < md_free;
    e_md    = i.v && i.hl && e_busy;
    e_stall = e_raw || e_md;
    e_iss   = i.v && !e_stall && !fl;
    if (!rst) begin
      e.cyc = cyc; e.stall = e_stall; e.issue = e_iss; e.busy = e_busy;
      e.raw = e_raw; e.mdst = e_md; e.s_raw = m_raw; e.s_md = m_md; e.s_iss = m_iss;
      q.push_back(e);
    end
    if (rst) begin
      foreach (avail[k]) avail[k] = 0;
      md_free = 0; m_raw = 0; m_md = 0; m_iss = 0;
    end else begin
      m_raw += e_raw; m_md += e_md; m_iss += e_iss;
      if (fl) begin
        foreach (avail[k]) avail[k] = 0;
        md_free = 0;
      end else if (e_iss) begin
        if (i.wr && i.wa != 0) avail[i.wa] = cyc + 1 + longint'(i.tn);
        if (i.md) md_free = cyc + 1 + (i.dv ? DL : ML);
      end
    end
    m_issued = e_iss && !rst;
    @(negedge clk);
    d_stalled = stall;
  endtask

  // Hold one instruction in D until the model says it issues; count DUT stall cycles.
  task automatic run(input ins_t i, input int exp_st, input string nm);
    bit iss, st;
    bit done = 1'b0;
    int n = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      step(i, 1'b0, 1'b0, iss, st);
      if (st) n++;
      if (iss) done = 1'b1;
    end
    if (!done) chk({nm, "_timeout"}, 0, 1);
    chk({nm, "_stalls"}, n, exp_st);
  endtask

  task automatic idle(input int n);
    bit iss, st;
    for (int k = 0; k < n; k++) step(bubble(), 1'b0, 1'b0, iss, st);
  endtask

  // Monitor: compare every queued prediction against the DUT away from the clock edge.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", stall, e.stall);
      chk("issue", issue, e.issue);
      chk("md_busy", md_busy, e.busy);
      chk("stall_raw", stall_raw, e.raw);
      chk("stall_md", stall_md, e.mdst);
`ifdef HAZARD_STATS_EN
      chk("stat_raw", stat_raw, e.s_raw);
      chk("stat_md", stat_md, e.s_md);
      chk("stat_issue", stat_issue, e.s_iss);
`endif
    end
  end

  initial begin
    ins_t lw1, addu_dep, beq1, addu1, addu0, beq0, mult, div, mfhi, lw4, addu4, lw9, addu9, rnd;
    bit   iss, st, fl, rst;
    lw1      = mk(0, 1, 0, 7, 1, 1, TNEW_LOAD, 0, 0, 0);
    addu_dep = mk(1, 1, 3, 1, 1, 2, TNEW_ALU, 0, 0, 0);
    beq1     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    addu1    = mk(2, 1, 3, 1, 1, 1, TNEW_ALU, 0, 0, 0);
    addu0    = mk(2, 1, 3, 1, 1, 0, TNEW_ALU, 0, 0, 0);
    beq0     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mult     = mk(5, 1, 6, 1, 0, 0, 0, 1, 1, 0);
    div      = mk(5, 1, 6, 1, 0, 0, 0, 1, 1, 1);
    mfhi     = mk(0, 7, 0, 7, 1, 8, TNEW_ALU, 1, 0, 0);
    lw4      = mk(0, 1, 0, 7, 1, 4, TNEW_LOAD, 0, 0, 0);
    addu4    = mk(4, 1, 4, 1, 1, 5, TNEW_ALU, 0, 0, 0);
    lw9      = mk(0, 1, 0, 7, 1, 9, TNEW_LOAD, 0, 0, 0);
    addu9    = mk(9, 0, 0, 7, 1, 10, TNEW_ALU, 0, 0, 0);

    step(bubble(), 1'b0, 1'b1, iss, st);
    step(bubble(), 1'b0, 1'b1, iss, st);
    // Reset state: first clean cycle with a valid instruction must not stall.
    run(beq0, 0, "after_reset");
    chk("reset_md_busy", md_busy, 0);

    run(lw1, 0, "lw");          run(addu_dep, 1, "lw_addu");   idle(4);
    run(lw1, 0, "lw");          run(beq1, 2, "lw_beq");        idle(4);
    run(addu1, 0, "alu");       run(beq1, 1, "alu_beq");       idle(4);
    run(addu0, 0, "alu_r0");    run(beq0, 0, "r0_beq");        idle(2);
    run(mult, 0, "mult");       run(mfhi, ML, "mult_mfhi");    idle(2);
    run(div, 0, "div");         run(mfhi, DL, "div_mfhi");     idle(2);

    // Flush the cycle after a load: the dependent consumer sees a clean scoreboard.
    run(lw4, 0, "lw4");
    step(bubble(), 1'b1, 1'b0, iss, st);
    run(addu4, 0, "flush_addu");
    idle(2);
    // Flush in the same cycle as a would-be issue: the load must not land.
    step(lw9, 1'b1, 1'b0, iss, st);
    run(addu9, 0, "flush_issue");
    idle(2);
    // Reset mid-mult clears the busy timer.
    run(mult, 0, "mult_rst");
    step(bubble(), 1'b0, 1'b1, iss, st);
    run(mfhi, 0, "reset_mfhi");
    idle(2);

`ifdef HAZARD_STATS_EN
    step(bubble(), 1'b0, 1'b1, iss, st);
    run(lw1, 0, "st_lw");
    run(addu_dep, 1, "st_addu");
    run(mult, 0, "st_mult");
    run(mfhi, ML, "st_mflo");
    step(bubble(), 1'b0, 1'b0, iss, st);
    chk("stat_raw_seq", stat_raw, 1);
    chk("stat_md_seq", stat_md, 5);
    chk("stat_issue_seq", stat_issue, 4);
`endif

    // Random traffic over a small register window so hazards are frequent.
    for (int n = 0; n < 2000; n++) begin
      rnd.v   = ($urandom % 8) != 0;
      rnd.rs  = 5'($urandom % 8);
      rnd.rt  = 5'($urandom % 8);
      rnd.trs = 3'($urandom % 8);
      rnd.trt = 3'($urandom % 8);
      rnd.wr  = ($urandom % 3) != 0;
      rnd.wa  = 5'($urandom % 8);
      rnd.tn  = 3'($urandom % 7);
      rnd.hl  = ($urandom % 6) == 0;
      rnd.md  = rnd.hl && (($urandom % 2) == 0);
      rnd.dv  = ($urandom % 2) == 0;
      fl      = ($urandom % 60) == 0;
      rst     = ($urandom % 300) == 0;
      step(rnd, fl, rst, iss, st);
    end
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
